// File: rtl/dclk_tx_arbiter_pkg.sv
// Shared link constants and arbiter state encodings for dclk_tx_arbiter.
package dclk_tx_arbiter_pkg;

  localparam int HDR_SZ  = 2;
  localparam int PL_SZ   = 8;
  localparam int ADDR_SZ = 4;
  localparam int FLIT_W  = HDR_SZ + PL_SZ + ADDR_SZ;

  typedef enum logic [1:0] {
    TXARB_IDLE   = 2'b00,
    TXARB_ISSUE  = 2'b01,
    TXARB_WSTART = 2'b10,
    TXARB_WDONE  = 2'b11
  } txarb_state_e;

endpackage

// File: rtl/dclk_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, searching upward from i_ptr+1 modulo N.
module rr_pick
  import dclk_tx_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  // First requester found after the pointer wins.
  always_comb begin : pick
    int            j;
    logic [IW-1:0] j_idx;
    logic          found;
    logic          hit;
    o_onehot = '0;
    o_idx    = '0;
    found    = 1'b0;
    j        = 0;
    j_idx    = '0;
    hit      = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j           = (int'(i_ptr) + k) % N;
      j_idx       = IW'(j);
      hit         = !found && i_req[j_idx];
      found       = found | hit;
      o_onehot[j_idx] = hit;
      o_idx       = hit ? j_idx : o_idx;
    end
    o_valid = |i_req;
  end

endmodule

// File: rtl/dclk_tx_arbiter.sv
// Round-robin arbiter feeding one dclk_tx serial transmitter.
// Optional TXARB_LOCAL_PRIO_EN: requester N_REQ-1 (local PE) gets strict priority.
module dclk_tx_arbiter
  import dclk_tx_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int GW        = 2,
  parameter int START_TMO = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_in,
  input  logic [N_REQ*FLIT_W-1:0] item_in,
  output logic [N_REQ-1:0]        grant,
  output logic [GW-1:0]           grant_idx,
  output logic                    tx_req,
  output logic [FLIT_W-1:0]       tx_item,
  input  logic                    tx_busy,
  input  logic                    tx_active,
  input  logic                    channel_busy,
  output logic                    busy,
  output logic                    tx_err
);

  localparam int W  = FLIT_W;
  localparam int CW = $clog2(START_TMO + 1);

  txarb_state_e       r_state;
  logic [GW-1:0]      r_ptr;
  logic [N_REQ-1:0]   r_grant;
  logic [GW-1:0]      r_grant_idx;
  logic               r_tx_req;
  logic [W-1:0]       r_tx_item;
  logic               r_busy;
  logic               r_tx_err;
  logic [CW-1:0]      r_cnt;

  logic               w_local;
  logic [N_REQ-1:0]   w_rr_req;
  logic [N_REQ-1:0]   w_rr_onehot;
  logic [GW-1:0]      w_rr_idx;
  logic               w_rr_valid;
  logic               w_any;
  logic [GW-1:0]      w_win_idx;
  logic [N_REQ-1:0]   w_win_onehot;
  logic [W-1:0]       w_item;

`ifdef TXARB_LOCAL_PRIO_EN
  // The local port bypasses rotation, so it is removed from the round-robin set.
  assign w_local  = req_in[N_REQ-1];
  assign w_rr_req = {1'b0, req_in[N_REQ-2:0]};
`else
  assign w_local  = 1'b0;
  assign w_rr_req = req_in;
`endif

  rr_pick #(.N(N_REQ), .IW(GW)) u_rr_pick (
    .i_req    (w_rr_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_rr_onehot),
    .o_idx    (w_rr_idx),
    .o_valid  (w_rr_valid)
  );

  assign w_any        = w_local | w_rr_valid;
  assign w_win_idx    = w_local ? GW'(N_REQ-1) : w_rr_idx;
  assign w_win_onehot = w_local ? {1'b1, {(N_REQ-1){1'b0}}} : w_rr_onehot;

  // Select the winner's flit from the flattened input bus.
  always_comb begin
    w_item = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_item = (w_win_idx == GW'(i)) ? item_in[i*W +: W] : w_item;
    end
  end

  // Arbitration FSM: issue one flit, then wait for the transfer to start and finish.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= TXARB_IDLE;
      r_ptr       <= GW'(N_REQ-1);
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_tx_req    <= 1'b0;
      r_tx_item   <= '0;
      r_busy      <= 1'b0;
      r_tx_err    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_grant  <= '0;
      r_tx_req <= 1'b0;
      r_tx_err <= 1'b0;
      case (r_state)
        TXARB_IDLE: begin
          if (w_any && !channel_busy && !tx_busy) begin
            r_state     <= TXARB_ISSUE;
            r_busy      <= 1'b1;
            r_grant     <= w_win_onehot;
            r_tx_req    <= 1'b1;
            r_grant_idx <= w_win_idx;
            r_tx_item   <= w_item;
            if (!w_local) begin
              r_ptr <= w_win_idx;
            end
          end
        end
        TXARB_ISSUE: begin
          r_state <= TXARB_WSTART;
          r_cnt   <= '0;
        end
        TXARB_WSTART: begin
          if (tx_active) begin
            r_state <= TXARB_WDONE;
          end else if (r_cnt == CW'(START_TMO-1)) begin
            r_tx_err <= 1'b1;
            r_state  <= TXARB_IDLE;
            r_busy   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        TXARB_WDONE: begin
          if (!tx_active && !tx_busy) begin
            r_state <= TXARB_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= TXARB_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign grant_idx = r_grant_idx;
  assign tx_req    = r_tx_req;
  assign tx_item   = r_tx_item;
  assign busy      = r_busy;
  assign tx_err    = r_tx_err;

endmodule
